// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch and program counter sequencer
module fetch_sequencer #(
  parameter int                   WORD_SIZE    = 16,
  parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0,
  parameter logic [7:0]           JUMP_OP_LO   = 8'h14,
  parameter logic [7:0]           JUMP_OP_HI   = 8'h24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [WORD_SIZE-1:0] program_counter_address,
  output logic [WORD_SIZE-1:0] instruction,
  output logic [WORD_SIZE-1:0] peek_jump_address,
  output logic                 instr_valid,
  input  logic                 exec_done,
  input  logic [WORD_SIZE-1:0] new_address,
  output logic                 fault
);

  typedef enum logic [2:0] {
    RST,
    FETCH_I,
    FETCH_OP,
    ISSUE,
    FAULT
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] pc_plus2;
  logic [7:0]           opcode;
  logic                 is_jump;

  // Operand word sits right after the instruction; wraps at the top of memory.
  assign pc_plus2 = pc + WORD_SIZE'(2);
  assign opcode   = mem_rdata[15:8];
  assign is_jump  = (opcode >= JUMP_OP_LO) && (opcode <= JUMP_OP_HI);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; all outputs are decoded from state and registers only.
  always_comb begin
    state_nxt   = state;
    mem_req     = 1'b0;
    mem_addr    = pc;
    instr_valid = 1'b0;
    fault       = 1'b0;
    case (state)
      RST: begin
        state_nxt = FETCH_I;
      end
      FETCH_I: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_nxt = is_jump ? FETCH_OP : ISSUE;
        end
      end
      FETCH_OP: begin
        mem_req  = 1'b1;
        mem_addr = pc_plus2;
        if (mem_ack) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (exec_done) begin
          state_nxt = new_address[0] ? FAULT : FETCH_I;
        end
      end
      FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_nxt = RST;
      end
    endcase
  end

  // Capture fetched words and the PC handed back by the decision logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc                      <= RESET_VECTOR;
      program_counter_address <= RESET_VECTOR;
      instruction             <= '0;
      peek_jump_address       <= '0;
    end else begin
      case (state)
        FETCH_I: begin
          if (mem_ack) begin
            instruction             <= mem_rdata;
            peek_jump_address       <= '0;
            program_counter_address <= pc;
          end
        end
        FETCH_OP: begin
          if (mem_ack) begin
            peek_jump_address       <= mem_rdata;
            program_counter_address <= pc_plus2;
          end
        end
        ISSUE: begin
          if (exec_done && !new_address[0]) begin
            pc <= new_address;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] program_counter_address;
  logic [15:0] instruction;
  logic [15:0] peek_jump_address;
  logic        instr_valid;
  logic        exec_done;
  logic [15:0] new_address;
  logic        fault;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [256];
  int          ack_delay  = 0;
  int          exec_delay = 0;
  int          wcnt       = 0;
  int          ecnt       = 0;
  logic        force_en   = 1'b0;
  logic [15:0] force_na   = 16'h0000;
  logic        stray_ack  = 1'b0;

  // Expected per-cycle values for the zero-wait program run.
  logic [15:0] e_req [13] = '{16'd1, 16'd0, 16'd1, 16'd0, 16'd1, 16'd1, 16'd0,
                              16'd1, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1};
  logic [15:0] e_adr [13] = '{16'h0000, 16'h0000, 16'h0002, 16'h0000, 16'h0004, 16'h0006, 16'h0000,
                              16'h0040, 16'h0042, 16'h0000, 16'h0050, 16'h0000, 16'h0052};
  logic [15:0] e_val [13] = '{16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd0, 16'd1,
                              16'd0, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0};
  logic [15:0] e_ins [13] = '{16'h0000, 16'h0102, 16'h0102, 16'h1300, 16'h1300, 16'h1400, 16'h1400,
                              16'h1400, 16'h2400, 16'h2400, 16'h2400, 16'h2500, 16'h2500};
  logic [15:0] e_pca [13] = '{16'h0000, 16'h0000, 16'h0000, 16'h0002, 16'h0002, 16'h0004, 16'h0006,
                              16'h0006, 16'h0040, 16'h0042, 16'h0042, 16'h0050, 16'h0050};
  logic [15:0] e_pk  [13] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0040,
                              16'h0040, 16'h0000, 16'h0050, 16'h0050, 16'h0000, 16'h0000};

  fetch_sequencer dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .mem_req                 (mem_req),
    .mem_addr                (mem_addr),
    .mem_ack                 (mem_ack),
    .mem_rdata               (mem_rdata),
    .program_counter_address (program_counter_address),
    .instruction             (instruction),
    .peek_jump_address       (peek_jump_address),
    .instr_valid             (instr_valid),
    .exec_done               (exec_done),
    .new_address             (new_address),
    .fault                   (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},   {15'b0, mem_req}, 16'h0000);
    check({tag, "_addr"},  mem_addr, 16'h0000);
    check({tag, "_valid"}, {15'b0, instr_valid}, 16'h0000);
    check({tag, "_fault"}, {15'b0, fault}, 16'h0000);
    check({tag, "_ins"},   instruction, 16'h0000);
    check({tag, "_pca"},   program_counter_address, 16'h0000);
    check({tag, "_peek"},  peek_jump_address, 16'h0000);
  endtask

  // Memory responder: acks after ack_delay requesting cycles.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (wcnt == ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr[7:0]];
          wcnt      = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack   = stray_ack;
        mem_rdata = 16'h1400;
        wcnt      = 0;
      end
    end
  end

  // Decision responder: jump to target if present, else fall through.
  initial begin
    exec_done   = 1'b0;
    new_address = 16'h0000;
    forever begin
      @(negedge clk);
      if (instr_valid) begin
        if (ecnt == exec_delay) begin
          exec_done   = 1'b1;
          new_address = force_en ? force_na :
                        (peek_jump_address != 16'h0000) ? peek_jump_address :
                        program_counter_address + 16'd2;
          ecnt        = 0;
        end else begin
          exec_done = 1'b0;
          ecnt++;
        end
      end else begin
        exec_done = 1'b0;
        ecnt      = 0;
      end
    end
  end

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 16'h0000;
    mem[8'h00] = 16'h0102;
    mem[8'h02] = 16'h1300;
    mem[8'h04] = 16'h1400;
    mem[8'h06] = 16'h0040;
    mem[8'h40] = 16'h2400;
    mem[8'h42] = 16'h0050;
    mem[8'h50] = 16'h2500;
    mem[8'h54] = 16'h0102;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;

    // Zero-wait program: non-jump, opcode boundaries, jumps.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      check($sformatf("row%0d_req", i), {15'b0, mem_req}, e_req[i]);
      if (e_req[i][0]) check($sformatf("row%0d_addr", i), mem_addr, e_adr[i]);
      check($sformatf("row%0d_valid", i), {15'b0, instr_valid}, e_val[i]);
      check($sformatf("row%0d_ins", i), instruction, e_ins[i]);
      check($sformatf("row%0d_pca", i), program_counter_address, e_pca[i]);
      check($sformatf("row%0d_peek", i), peek_jump_address, e_pk[i]);
      if (i == 11) begin
        #2;
        ack_delay  = 3;
        exec_delay = 4;
      end
    end

    // Memory stall: request held for three more cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mstall_req", {15'b0, mem_req}, 16'h0001);
      check("mstall_addr", mem_addr, 16'h0052);
      check("mstall_valid", {15'b0, instr_valid}, 16'h0000);
    end

    // Execute stall: presented outputs held for five cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("estall_valid", {15'b0, instr_valid}, 16'h0001);
      check("estall_ins", instruction, 16'h0000);
      check("estall_pca", program_counter_address, 16'h0052);
      check("estall_peek", peek_jump_address, 16'h0000);
      check("estall_req", {15'b0, mem_req}, 16'h0000);
      if (i == 0) begin
        #2;
        ack_delay = 0;
      end
    end
    #2;
    exec_delay = 0;
    force_en   = 1'b1;
    force_na   = 16'h0041;

    @(negedge clk);
    check("post_stall_req", {15'b0, mem_req}, 16'h0001);
    check("post_stall_addr", mem_addr, 16'h0054);
    @(negedge clk);
    check("pre_fault_valid", {15'b0, instr_valid}, 16'h0001);
    check("pre_fault_fault", {15'b0, fault}, 16'h0000);

    // Misaligned target: sticky fault, no further requests.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("fault_flag", {15'b0, fault}, 16'h0001);
      check("fault_req", {15'b0, mem_req}, 16'h0000);
      check("fault_valid", {15'b0, instr_valid}, 16'h0000);
    end

    #2;
    rst_n    = 1'b0;
    force_en = 1'b0;
    #1;
    check_reset_vals("fault_rst");
    stray_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    stray_ack = 1'b0;
    @(negedge clk);
    check("stray_ins", instruction, 16'h0000);
    check("stray_req", {15'b0, mem_req}, 16'h0001);
    check("stray_addr", mem_addr, 16'h0000);
    @(negedge clk);
    check("restart_ins", instruction, 16'h0102);
    check("restart_valid", {15'b0, instr_valid}, 16'h0001);

    // Walk to the operand fetch of the jump at 0x0004, then reset mid-fetch.
    repeat (4) @(negedge clk);
    check("fop_req", {15'b0, mem_req}, 16'h0001);
    check("fop_addr", mem_addr, 16'h0006);
    check("fop_ins", instruction, 16'h1400);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("fop_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_req", {15'b0, mem_req}, 16'h0001);
    check("rel_addr", mem_addr, 16'h0000);
    check("rel_peek", peek_jump_address, 16'h0000);
    @(negedge clk);
    check("rel_ins", instruction, 16'h0102);
    check("rel_pca", program_counter_address, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
